mgmt_sensor_poller: RTL and testbench

//  Sequences the shared on-die sensor DRP port (XADC-style) for the management engine. Round-robin sweeps a channel

---
 rtl/mgmt_sensor_poller_if.sv | 34 +++
 rtl/mgmt_sensor_poller.sv | 147 ++++++++++++++
 tb/tb_mgmt_sensor_poller.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mgmt_sensor_poller_if.sv
// DRP master port and host request/response channel of the management sensor poller.
// The master modport is the poller's view; slave is the DRP block plus host side.
interface mgmt_sensor_poller_if;
    logic        drp_en;
    logic        drp_we;
    logic [6:0]  drp_addr;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_rdy;

    logic        host_req_valid;
    logic        host_req_ready;
    logic        host_req_write;
    logic [6:0]  host_req_addr;
    logic [15:0] host_req_wdata;

    logic        host_rsp_valid;
    logic [15:0] host_rsp_data;
    logic        host_rsp_timeout;

    modport master (
        output drp_en, drp_we, drp_addr, drp_di,
        input  drp_do, drp_rdy,
        input  host_req_valid, host_req_write, host_req_addr, host_req_wdata,
        output host_req_ready, host_rsp_valid, host_rsp_data, host_rsp_timeout
    );

    modport slave (
        input  drp_en, drp_we, drp_addr, drp_di,
        output drp_do, drp_rdy,
        output host_req_valid, host_req_write, host_req_addr, host_req_wdata,
        input  host_req_ready, host_rsp_valid, host_rsp_data, host_rsp_timeout
    );
endinterface

// File: rtl/mgmt_sensor_poller.sv
// Shares one DRP port between a periodic round-robin channel sweep and host requests,
// caching each channel's latest reading and aborting transactions that never complete.
module mgmt_sensor_poller #(
    parameter int unsigned         NUM_CH        = 4,
    parameter logic [NUM_CH*7-1:0] CH_ADDRS      = {7'h06, 7'h02, 7'h01, 7'h00},
    parameter int unsigned         POLL_INTERVAL = 1000,
    parameter int unsigned         TIMEOUT       = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mgmt_sensor_poller_if.master   bus,
    output logic [NUM_CH*16-1:0]   ch_value,
    output logic [NUM_CH-1:0]      ch_updated,
    output logic                   sweep_done,
    output logic [15:0]            timeout_count
);

    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT);
    localparam int unsigned IV_W   = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [IV_W-1:0]   IV_RELOAD = IV_W'(POLL_INTERVAL - 1);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {GRANT_POLL, GRANT_HOST} grant_t;

    state_t              state_q, state_d;
    grant_t              last_grant;
    logic                poll_pending;
    logic [IV_W-1:0]     iv_cnt;
    logic [CH_W-1:0]     ch_idx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                cur_host;
    logic                host_win, poll_win, rdy_hit, tmo_hit;
    logic [6:0]          poll_addr;
    logic [15:0]         ch_val [NUM_CH];

    // Host wins unless a poll is pending and the host had the previous grant,
    // so simultaneous demand alternates between the two sources.
    always_comb begin
        state_d  = state_q;
        host_win = 1'b0;
        poll_win = 1'b0;
        rdy_hit  = 1'b0;
        tmo_hit  = 1'b0;
        case (state_q)
            IDLE: begin
                host_win = rst_n && bus.host_req_valid &&
                           (!poll_pending || last_grant == GRANT_POLL);
                poll_win = rst_n && !host_win && poll_pending;
                if (host_win || poll_win) state_d = WAIT;
            end
            WAIT: begin
                rdy_hit = bus.drp_rdy;
                tmo_hit = !bus.drp_rdy && (wait_cnt == WAIT_LAST);
                if (rdy_hit || tmo_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.host_req_ready = host_win;
    assign poll_addr = CH_ADDRS[int'(ch_idx) * 7 +: 7];

    always_comb begin
        ch_value = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) ch_value[i*16 +: 16] = ch_val[i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.drp_en           <= 1'b0;
            bus.drp_we           <= 1'b0;
            bus.drp_addr         <= '0;
            bus.drp_di           <= '0;
            bus.host_rsp_valid   <= 1'b0;
            bus.host_rsp_data    <= '0;
            bus.host_rsp_timeout <= 1'b0;
            ch_updated           <= '0;
            sweep_done           <= 1'b0;
            timeout_count        <= '0;
            last_grant           <= GRANT_POLL;
            poll_pending         <= 1'b1;
            iv_cnt               <= '0;
            ch_idx               <= '0;
            wait_cnt             <= '0;
            cur_host             <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) ch_val[i] <= '0;
        end else begin
            bus.drp_en         <= 1'b0;
            bus.host_rsp_valid <= 1'b0;
            ch_updated         <= '0;
            sweep_done         <= 1'b0;

            if (!poll_pending) begin
                if (iv_cnt == '0) poll_pending <= 1'b1;
                else              iv_cnt <= iv_cnt - 1'b1;
            end

            if (host_win || poll_win) begin
                bus.drp_en   <= 1'b1;
                bus.drp_we   <= host_win ? bus.host_req_write : 1'b0;
                bus.drp_addr <= host_win ? bus.host_req_addr  : poll_addr;
                bus.drp_di   <= host_win ? bus.host_req_wdata : '0;
                cur_host     <= host_win;
                last_grant   <= host_win ? GRANT_HOST : GRANT_POLL;
                wait_cnt     <= '0;
            end

            if (state_q == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
                if (rdy_hit || tmo_hit) begin
                    if (tmo_hit && timeout_count != 16'hFFFF)
                        timeout_count <= timeout_count + 16'd1;
                    if (cur_host) begin
                        bus.host_rsp_valid   <= 1'b1;
                        bus.host_rsp_data    <= (rdy_hit && !bus.drp_we) ? bus.drp_do : '0;
                        bus.host_rsp_timeout <= tmo_hit;
                    end else begin
                        if (rdy_hit) begin
                            ch_val[ch_idx]     <= bus.drp_do;
                            ch_updated[ch_idx] <= 1'b1;
                        end
                        // Poll pending stays set until the sweep wraps, so the interval
                        // counter never runs while a sweep is in progress.
                        if (ch_idx == LAST_CH) begin
                            ch_idx       <= '0;
                            sweep_done   <= 1'b1;
                            poll_pending <= 1'b0;
                            iv_cnt       <= IV_RELOAD;
                        end else begin
                            ch_idx <= ch_idx + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mgmt_sensor_poller.sv
// Scoreboard bench for mgmt_sensor_poller: a DRP responder model plus a monitor that pops
// expected strobes, responses and channel updates as the DUT presents them.
module tb_mgmt_sensor_poller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] ch_value;
    logic [3:0]  ch_updated;
    logic        sweep_done;
    logic [15:0] timeout_count;

    mgmt_sensor_poller_if bus ();

    mgmt_sensor_poller #(
        .NUM_CH        (4),
        .CH_ADDRS      ({7'h06, 7'h02, 7'h01, 7'h00}),
        .POLL_INTERVAL (1000),
        .TIMEOUT       (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .ch_value      (ch_value),
        .ch_updated    (ch_updated),
        .sweep_done    (sweep_done),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [23:0] exp_host [$];   // {we, addr, wdata}
    logic [6:0]  exp_poll [$];
    logic [16:0] exp_rsp  [$];   // {data, timeout}
    logic [17:0] exp_upd  [$];   // {channel, value}
    bit          src_log  [$];   // 1 = host strobe, 0 = poll strobe
    int          poll_en_cyc [$];
    int          sweep_cyc   [$];
    int          cyc = 0;
    int          sweep_count = 0;

    bit           m_busy = 0, m_host = 0, m_rdy_host = 0, m_we = 0;
    int           m_left = 0;
    logic [6:0]   m_addr = '0;
    bit           stray_req = 0, accept_prev = 0, rsp_due = 0;
    logic [127:0] hang_mask = '0;
    logic [6:0]   slow_addr = 7'h7F;
    int           slow_delay = 3;
    logic [15:0]  data_xor = '0;

    function automatic logic [15:0] model_data(input logic [6:0] a);
        case (a)
            7'h00:   return 16'h0123;
            7'h01:   return 16'h4567;
            7'h02:   return 16'h89AB;
            7'h06:   return 16'hCDEF;
            7'h10:   return 16'hBEEF;
            default: return 16'h5A5A;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_unexp(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h, expected nothing", name, act);
    endtask

    // DRP responder (drives after the edge) and monitor (samples on the falling edge)
    initial begin
        bus.drp_rdy = 1'b0;
        bus.drp_do  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            bus.drp_rdy = 1'b0;
            bus.drp_do  = '0;
            m_rdy_host  = 0;
            if (!rst_n) m_busy = 0;
            if (stray_req) begin
                stray_req   = 0;
                bus.drp_rdy = 1'b1;
                bus.drp_do  = 16'hDEAD;
            end else if (m_busy) begin
                m_left--;
                if (m_left <= 0) begin
                    m_busy      = 0;
                    bus.drp_rdy = 1'b1;
                    bus.drp_do  = m_we ? 16'hFFFF : (model_data(m_addr) ^ data_xor);
                    m_rdy_host  = m_host;
                end
            end

            @(negedge clk);
            if (rsp_due) begin
                rsp_due = 0;
                chk("rdy_to_rsp_latency", bus.host_rsp_valid, 1);
            end
            if (accept_prev) chk("accept_to_en_latency", bus.drp_en, 1);
            if (bus.drp_en) begin
                m_busy = !hang_mask[bus.drp_addr];
                m_left = (bus.drp_addr == slow_addr) ? slow_delay : 3;
                m_addr = bus.drp_addr;
                m_we   = bus.drp_we;
                m_host = accept_prev;
                if (accept_prev) begin
                    src_log.push_back(1);
                    if (exp_host.size() == 0)
                        fail_unexp("host_drp", {bus.drp_we, bus.drp_addr, bus.drp_di});
                    else
                        chk("host_drp", {bus.drp_we, bus.drp_addr, bus.drp_di}, exp_host.pop_front());
                end else begin
                    src_log.push_back(0);
                    poll_en_cyc.push_back(cyc);
                    if (exp_poll.size() == 0)
                        fail_unexp("poll_drp", {bus.drp_we, bus.drp_addr});
                    else
                        chk("poll_drp", {bus.drp_we, bus.drp_addr}, {1'b0, exp_poll.pop_front()});
                end
            end
            accept_prev = rst_n && bus.host_req_valid && bus.host_req_ready;
            if (bus.host_rsp_valid) begin
                if (exp_rsp.size() == 0)
                    fail_unexp("host_rsp", {bus.host_rsp_data, bus.host_rsp_timeout});
                else
                    chk("host_rsp", {bus.host_rsp_data, bus.host_rsp_timeout}, exp_rsp.pop_front());
            end
            if (ch_updated != '0) begin
                if (exp_upd.size() == 0) begin
                    fail_unexp("ch_updated", ch_updated);
                end else begin
                    logic [17:0] e;
                    int          idx;
                    e   = exp_upd.pop_front();
                    idx = int'(e[17:16]);
                    chk("ch_updated", ch_updated, 4'b0001 << idx);
                    chk("ch_value_on_update", ch_value[idx*16 +: 16], e[15:0]);
                end
            end
            if (sweep_done) begin
                sweep_cyc.push_back(cyc);
                sweep_count++;
            end
            if (bus.drp_rdy && rst_n && m_rdy_host) rsp_due = 1;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic host_op(input logic we, input logic [6:0] a, input logic [15:0] d,
                           input logic [15:0] edata, input logic etmo, input bit ersp,
                           input bit keep);
        bit ok;
        ok = 0;
        bus.host_req_valid = 1'b1;
        bus.host_req_write = we;
        bus.host_req_addr  = a;
        bus.host_req_wdata = d;
        exp_host.push_back({we, a, d});
        if (ersp) exp_rsp.push_back({edata, etmo});
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.host_req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_unexp("host_accept_timeout", {a});
        @(posedge clk);
        #1;
        if (!keep || !ok) bus.host_req_valid = 1'b0;
    endtask

    task automatic wait_sweeps(input int n, input int budget);
        for (int i = 0; i < budget && sweep_count < n; i++) @(posedge clk);
        if (sweep_count < n) fail_unexp("sweep_wait_timeout", sweep_count);
    endtask

    task automatic wait_rsp(input int budget);
        for (int i = 0; i < budget && exp_rsp.size() != 0; i++) @(posedge clk);
        if (exp_rsp.size() != 0) fail_unexp("rsp_wait_timeout", exp_rsp.size());
    endtask

    task automatic push_sweep(input logic [15:0] v0, input logic [15:0] v1,
                              input logic [15:0] v2, input logic [15:0] v3, input bit skip1);
        exp_poll.push_back(7'h00);
        exp_poll.push_back(7'h01);
        exp_poll.push_back(7'h02);
        exp_poll.push_back(7'h06);
        exp_upd.push_back({2'd0, v0});
        if (!skip1) exp_upd.push_back({2'd1, v1});
        exp_upd.push_back({2'd2, v2});
        exp_upd.push_back({2'd3, v3});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ord;
        rst_n              = 1'b0;
        bus.host_req_valid = 1'b0;
        bus.host_req_write = 1'b0;
        bus.host_req_addr  = '0;
        bus.host_req_wdata = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {bus.drp_en, bus.host_req_ready, bus.host_rsp_valid, bus.host_rsp_data,
                              bus.host_rsp_timeout, ch_updated, sweep_done, timeout_count}, 0);
        chk("reset_ch_value", ch_value, 0);

        // First sweep with host requests held pending: grants alternate, host first.
        push_sweep(16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        host_op(1'b0, 7'h10, 16'h0000, 16'hBEEF, 1'b0, 1, 1);
        host_op(1'b1, 7'h11, 16'h1234, 16'h0000, 1'b0, 1, 1);
        host_op(1'b0, 7'h12, 16'h0000, 16'h5A5A, 1'b0, 1, 0);
        wait_sweeps(1, 500);
        @(negedge clk);
        chk("grant_count", src_log.size(), 7);
        ord = '0;
        for (int i = 0; i < src_log.size() && i < 7; i++) ord[6-i] = src_log[i];
        chk("grant_order", ord, 7'b1010100);
        src_log.delete();
        chk("sweep1_values", ch_value, {16'hCDEF, 16'h89AB, 16'h4567, 16'h0123});

        // Host read in the idle gap between sweeps
        @(posedge clk);
        #1;
        host_op(1'b0, 7'h10, 16'h0000, 16'hBEEF, 1'b0, 1, 0);
        wait_rsp(200);
        @(negedge clk);
        chk("sweep_count_gap", sweep_count, 1);

        // Second sweep: ch1 hangs, ch2 answers on the last allowed cycle
        hang_mask[1] = 1'b1;
        slow_addr    = 7'h02;
        slow_delay   = 63;
        data_xor     = 16'h00FF;
        push_sweep(16'h01DC, 16'h0000, 16'h8954, 16'hCD10, 1);
        wait_sweeps(2, 2000);
        @(negedge clk);
        if (poll_en_cyc.size() >= 8 && sweep_cyc.size() >= 1) begin
            chk("poll_interval", poll_en_cyc[4] - sweep_cyc[0], 1001);
            chk("hang_abort_gap", poll_en_cyc[6] - poll_en_cyc[5], 65);
        end else begin
            fail_unexp("poll_strobe_count", poll_en_cyc.size());
        end
        chk("timeout_count_1", timeout_count, 1);
        chk("sweep2_values", ch_value, {16'hCD10, 16'h8954, 16'h4567, 16'h01DC});

        // Host read that times out, then a host write
        hang_mask[1] = 1'b0;
        slow_addr    = 7'h7F;
        hang_mask[32] = 1'b1;
        @(posedge clk);
        #1;
        host_op(1'b0, 7'h20, 16'h0000, 16'h0000, 1'b1, 1, 0);
        host_op(1'b1, 7'h15, 16'hA5A5, 16'h0000, 1'b0, 1, 0);
        wait_rsp(300);
        @(negedge clk);
        chk("timeout_count_2", timeout_count, 2);

        // Reset while a host read is outstanding; no response may follow
        @(posedge clk);
        #1;
        host_op(1'b0, 7'h10, 16'h0000, 16'h0000, 1'b0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midwait_reset_outputs", {bus.drp_en, bus.host_req_ready, bus.host_rsp_valid, bus.host_rsp_data,
                                      bus.host_rsp_timeout, ch_updated, sweep_done, timeout_count}, 0);
        chk("midwait_reset_ch_value", ch_value, 0);
        push_sweep(16'h01DC, 16'h4598, 16'h8954, 16'hCD10, 0);
        stray_req = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_sweeps(3, 500);
        @(negedge clk);
        chk("fresh_sweep_values", ch_value, {16'hCD10, 16'h8954, 16'h4598, 16'h01DC});
        chk("fresh_timeout_count", timeout_count, 0);
        chk("queues_drained", {exp_host.size(), exp_poll.size(), exp_rsp.size(), exp_upd.size()}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
